// File: rtl/regfile_pkg.sv
// Shared defaults and types for the multi-port integer register file.
// Optional build macro: REGFILE_BYPASS_EN (same-cycle write-to-read bypass).
package regfile_pkg;

  localparam int XLEN_DEF     = 32;
  localparam int NUM_REGS_DEF = 32;
  localparam int ADDR_W_DEF   = $clog2(NUM_REGS_DEF);

  typedef logic [ADDR_W_DEF-1:0] reg_idx_t;
  typedef logic [XLEN_DEF-1:0]   xlen_t;

  localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: issue marks a destination pending, writeback clears it.
// With REGFILE_BYPASS_EN a same-cycle writeback hides busy on the read ports.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NUM_REGS = NUM_REGS_DEF,
  parameter  int NUM_RD   = 2,
  parameter  int NUM_WR   = 1,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     iss_v,
  input  logic [ADDR_W-1:0]        iss_rd,
  input  logic [NUM_WR*ADDR_W-1:0] rd_num,
  input  logic [NUM_WR-1:0]        reg_w,
  input  logic [NUM_RD*ADDR_W-1:0] rs_num,
  output logic [NUM_RD-1:0]        rs_busy
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_REGS-1:0] wb_hit;
  logic [NUM_REGS-1:0] iss_hit;

  always_comb begin
    wb_hit  = '0;
    iss_hit = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      if (reg_w[w] && (rd_num[w*ADDR_W +: ADDR_W] != ADDR_W'(REG_ZERO))) begin
        wb_hit[rd_num[w*ADDR_W +: ADDR_W]] = 1'b1;
      end
    end
    if (iss_v && (iss_rd != ADDR_W'(REG_ZERO))) begin
      iss_hit[iss_rd] = 1'b1;
    end
    // Set beats clear: a new producer is in flight for that register.
    busy_d    = (busy_q & ~wb_hit) | iss_hit;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_comb begin
    rs_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rs_busy[k] = busy_q[rs_num[k*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
      if (wb_hit[rs_num[k*ADDR_W +: ADDR_W]] && !iss_hit[rs_num[k*ADDR_W +: ADDR_W]]) begin
        rs_busy[k] = 1'b0;
      end
`endif
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with x0 hardwired to zero and busy scoreboard.
// Optional build macro: REGFILE_BYPASS_EN (same-cycle write data visible on reads).
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int XLEN     = XLEN_DEF,
  parameter  int NUM_REGS = NUM_REGS_DEF,
  parameter  int NUM_RD   = 2,
  parameter  int NUM_WR   = 1,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rs_num,
  output logic [NUM_RD*XLEN-1:0]   rs_data,
  output logic [NUM_RD-1:0]        rs_busy,
  input  logic [NUM_WR*ADDR_W-1:0] rd_num,
  input  logic [NUM_WR*XLEN-1:0]   rd_data,
  input  logic [NUM_WR-1:0]        reg_w,
  input  logic                     iss_v,
  input  logic [ADDR_W-1:0]        iss_rd
);

  typedef logic [XLEN-1:0] word_t;

  word_t regs_q [NUM_REGS];
  word_t regs_d [NUM_REGS];

  // Ascending port order lets the highest-numbered writer win a conflict.
  always_comb begin
    regs_d = regs_q;
    for (int w = 0; w < NUM_WR; w++) begin
      if (reg_w[w] && (rd_num[w*ADDR_W +: ADDR_W] != ADDR_W'(REG_ZERO))) begin
        regs_d[rd_num[w*ADDR_W +: ADDR_W]] = rd_data[w*XLEN +: XLEN];
      end
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rs_data = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (rs_num[k*ADDR_W +: ADDR_W] != ADDR_W'(REG_ZERO)) begin
        rs_data[k*XLEN +: XLEN] = regs_q[rs_num[k*ADDR_W +: ADDR_W]];
      end
`ifdef REGFILE_BYPASS_EN
      for (int w = 0; w < NUM_WR; w++) begin
        if (reg_w[w] && (rd_num[w*ADDR_W +: ADDR_W] == rs_num[k*ADDR_W +: ADDR_W]) &&
            (rd_num[w*ADDR_W +: ADDR_W] != ADDR_W'(REG_ZERO))) begin
          rs_data[k*XLEN +: XLEN] = rd_data[w*XLEN +: XLEN];
        end
      end
`endif
    end
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_RD   (NUM_RD),
    .NUM_WR   (NUM_WR)
  ) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .iss_v   (iss_v),
    .iss_rd  (iss_rd),
    .rd_num  (rd_num),
    .reg_w   (reg_w),
    .rs_num  (rs_num),
    .rs_busy (rs_busy)
  );

endmodule
